// File: rtl/ksa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ksa_seq_ctrl
//
// Sequences an N-word (W bits per word) add/subtract through one external
// W-bit Kogge-Stone adder slice. One word is processed per clock, least
// significant word first, with the slice carry-out fed back as the next
// word's carry-in. Subtraction is formed as A + ~B + 1.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (a, b, c_in, op)
//   a, b                  W*N-bit operands, word 0 = bits [W-1:0]
//   c_in                  carry-in for op = 0
//   op                    0 = A + B + c_in, 1 = A - B
//   clr                   synchronous abort of the transaction in flight
//   slice_a/b/cin         word and carry driven to the external slice
//   slice_sum/cout        combinational result returned by the slice
//   sum, c_out            result, qualified by out_valid
//   out_valid / out_ready result handshake
//   busy                  transaction in flight (RUN or DONE)
// ---------------------------------------------------------------------------
module ksa_seq_ctrl #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*N-1:0] a,
  input  logic [W*N-1:0] b,
  input  logic           c_in,
  input  logic           op,
  input  logic           clr,
  output logic [W-1:0]   slice_a,
  output logic [W-1:0]   slice_b,
  output logic           slice_cin,
  input  logic [W-1:0]   slice_sum,
  input  logic           slice_cout,
  output logic [W*N-1:0] sum,
  output logic           c_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [W*N-1:0]  a_reg;
  logic [W*N-1:0]  b_reg;     // already inverted for subtraction
  logic [W*N-1:0]  sum_reg;
  logic            carry_reg;
  logic            c_out_reg;
  logic [IW-1:0]   idx;

  logic            accept;
  logic            last_word;

  assign accept    = (state == IDLE) && in_valid && !clr;
  assign last_word = (idx == IW'(N - 1));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic; clr outranks both handshakes.
  // -------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so every path assigns
  // it; a missing branch would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = RUN;
      end
      RUN: begin
        if (clr)            next_state = IDLE;
        else if (last_word) next_state = DONE;
      end
      DONE: begin
        // in_ready is low here, so the exit edge can never also accept.
        if (clr || out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the result register is reset so sum reads 0 out of reset; it is a
  // plain flop vector, not a RAM, so resetting it is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= op ? ~b : b;
            carry_reg <= op ? 1'b1 : c_in;
            idx       <= '0;
          end
        end
        RUN: begin
          if (!clr) begin
            // Words not yet reached keep their old contents.
            sum_reg[idx*W +: W] <= slice_sum;
            carry_reg           <= slice_cout;
            if (last_word) begin
              c_out_reg <= slice_cout;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Slice drive: only meaningful in RUN, held at zero otherwise.
  // -------------------------------------------------------------------------
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_reg[idx*W +: W];
      slice_b   = b_reg[idx*W +: W];
      slice_cin = carry_reg;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ksa_seq_ctrl
//
// Bench for ksa_seq_ctrl (W=16, N=4). Models the external slice as a plain
// 16-bit adder, drives a table of requests plus hand-written corner-case
// sequences, and compares results popped from an expected-value queue.
// ---------------------------------------------------------------------------
module tb_ksa_seq_ctrl;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int DW = W * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          c_in = 1'b0;
  logic          op = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  slice_a;
  logic [W-1:0]  slice_b;
  logic          slice_cin;
  logic [W-1:0]  slice_sum;
  logic          slice_cout;
  logic [DW-1:0] sum;
  logic          c_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  // External KSA slice: combinational W-bit adder.
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{W{1'b0}}, slice_cin};

  ksa_seq_ctrl #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .c_in       (c_in),
    .op         (op),
    .clr        (clr),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout),
    .sum        (sum),
    .c_out      (c_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c_in;
    logic          op;
    logic [DW-1:0] exp_sum;
    logic          exp_cout;
    int            exp_cin_cnt;   // -1: not checked
    int            stall;
  } vec_t;

  typedef struct {
    logic [DW-1:0] sum;
    logic          cout;
  } exp_t;

  vec_t tbl[6];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference arithmetic, independent of word sequencing.
  task automatic push_model(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                            input logic tcin, input logic top);
    logic [DW:0] r;
    exp_t e;
    r = {1'b0, ta} + {1'b0, (top ? ~tb : tb)} + {{DW{1'b0}}, (top ? 1'b1 : tcin)};
    e.sum  = r[DW-1:0];
    e.cout = r[DW];
    exp_q.push_back(e);
  endtask

  task automatic push_exp(input logic [DW-1:0] s, input logic co);
    exp_t e;
    e.sum  = s;
    e.cout = co;
    exp_q.push_back(e);
  endtask

  // Called #1 after an edge. Presents a request and returns #1 after the
  // accept edge (DUT in RUN, idx 0).
  task automatic send(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                      input logic tcin, input logic top);
    int waited;
    a = ta; b = tb; c_in = tcin; op = top;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_before_send", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  // Called right after send(). Measures latency, counts slice_cin=1 over RUN
  // cycles, compares the result, stalls, then releases with out_ready.
  task automatic collect(input int stall, output int cin_cnt);
    int   lat;
    exp_t e;
    logic [DW-1:0] s0;
    logic c0;
    cin_cnt = int'(slice_cin);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
      cin_cnt += int'(slice_cin);
    end
    check("latency", 64'(lat), 64'(N));
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check("sum", sum, e.sum);
      check("c_out", 64'(c_out), 64'(e.cout));
    end
    s0 = sum;
    c0 = c_out;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_sum", sum, s0);
      check("stall_cout", 64'(c_out), 64'(c0));
      check("stall_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("exit_valid", 64'(out_valid), 64'(0));
    check("exit_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_sum"},       sum,            64'(0));
    check({tag, "_c_out"},     64'(c_out),     64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_slice_a"},   64'(slice_a),   64'(0));
    check({tag, "_slice_b"},   64'(slice_b),   64'(0));
    check({tag, "_slice_cin"}, 64'(slice_cin), 64'(0));
  endtask

  initial begin
    int cc;
    logic [DW-1:0] ra, rb;
    logic rc, ro;

    tbl[0] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0, 1'b1, 3, 0};
    tbl[1] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, -1, 1};
    tbl[2] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, -1, 0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 4, 2};
    tbl[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
               64'h2222_2222_2222_2212, 1'b0, -1, 0};
    tbl[5] = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 0};

    // Reset state
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check_reset_outputs("post_reset");

    // Table-driven requests
    for (int i = 0; i < 6; i++) begin
      push_exp(tbl[i].exp_sum, tbl[i].exp_cout);
      send(tbl[i].a, tbl[i].b, tbl[i].c_in, tbl[i].op);
      collect(tbl[i].stall, cc);
      if (tbl[i].exp_cin_cnt >= 0) check("slice_cin_count", 64'(cc), 64'(tbl[i].exp_cin_cnt));
      check("idle_slice_a", 64'(slice_a), 64'(0));
    end

    // Random requests against the reference model
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      push_model(ra, rb, rc, ro);
      send(ra, rb, rc, ro);
      collect(i, cc);
    end

    // Backpressure with a waiting request: no accept until after DONE exits
    push_exp(64'h2, 1'b1);
    send(64'h7, 64'h5, 1'b0, 1'b1);
    a = 64'h3; b = 64'h4; c_in = 1'b0; op = 1'b0;
    in_valid = 1'b1;
    collect(3, cc);
    push_exp(64'h7, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_next_edge", 64'(busy), 64'(1));
    collect(0, cc);

    // clr with idx = 2
    send(64'hAAAA, 64'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", 64'(busy), 64'(0));
    check("clr_in_ready", 64'(in_ready), 64'(1));
    cc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cc += int'(out_valid);
    end
    check("clr_no_valid", 64'(cc), 64'(0));
    push_exp(64'h7, 1'b0);
    send(64'h3, 64'h4, 1'b0, 1'b0);
    collect(0, cc);

    // Reset pulse with idx = 1
    send(64'hFFFF_0000, 64'h1234, 1'b1, 1'b0);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_in_ready", 64'(in_ready), 64'(1));
    push_exp(64'h1_FFFF, 1'b0);
    send(64'h1_0000, 64'hFFFF, 1'b0, 1'b0);
    collect(0, cc);

    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Overall time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ksa_seq_ctrl.md
KSA_SEQ_CTRL -- requirements
Module: ksa_seq_ctrl

Interface
REQ-001 Parameter W, default 16, width in bits of the external KSA slice.
REQ-002 Parameter N, default 4, number of W-bit words per operand; N >= 2.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request present on a, b, c_in, op.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  W*N  operand A, word 0 = bits [W-1:0].
REQ-008 b  input  W*N  operand B.
REQ-009 c_in  input  1  carry-in, used when op=0.
REQ-010 op  input  1  0 = A+B+c_in, 1 = A-B (A + ~B + 1).
REQ-011 clr  input  1  synchronous abort of the transaction in flight.
REQ-012 slice_a  output  W  A word driven to the external slice.
REQ-013 slice_b  output  W  B word (inverted when op=1) driven to the slice.
REQ-014 slice_cin  output  1  carry into the slice.
REQ-015 slice_sum  input  W  combinational sum returned by the slice, same cycle.
REQ-016 slice_cout  input  1  combinational carry-out returned by the slice, same cycle.
REQ-017 sum  output  W*N  result, valid while out_valid=1.
REQ-018 c_out  output  1  final carry-out, valid while out_valid=1.
REQ-019 out_valid  output  1  result present.
REQ-020 out_ready  input  1  consumer accepts the result.
REQ-021 busy  output  1  high in RUN or DONE.

Function
REQ-022 The FSM SHALL have states IDLE, RUN and DONE and no others.
REQ-023 in_ready SHALL be 1 only in IDLE.
REQ-024 On an IDLE edge with in_valid=1 and clr=0, the block SHALL latch a and b, latch (op ? ~b : b) as the B register, load carry_reg with (op ? 1 : c_in), clear idx to 0, and enter RUN.
REQ-025 In RUN, slice_a SHALL be A word idx, slice_b SHALL be B-register word idx, and slice_cin SHALL be carry_reg.
REQ-026 On each RUN edge, the block SHALL write slice_sum into sum word idx, load carry_reg with slice_cout, and increment idx.
REQ-027 On the RUN edge with idx = N-1, the block SHALL instead enter DONE, set out_valid=1, and set c_out to slice_cout.
REQ-028 Latency: out_valid SHALL rise exactly N edges after the accept edge; throughput SHALL be one request per N+2 cycles at most.
REQ-029 In DONE, sum, c_out and out_valid SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE with out_valid=0.
REQ-030 No request SHALL be accepted on the same edge that DONE exits.
REQ-031 Outside RUN, slice_a, slice_b and slice_cin SHALL be driven to 0.
REQ-032 clr=1 in RUN or DONE SHALL force IDLE with out_valid=0 on the next edge, discarding results; clr SHALL take priority over in_valid and out_ready.
REQ-033 idx SHALL be ceil(log2 N) bits wide and SHALL never exceed N-1.
REQ-034 sum words not yet written in a transaction SHALL retain their previous values; only out_valid qualifies sum.

Reset
REQ-035 While rst_n=0, the block SHALL be in IDLE with out_valid=0, sum=0, c_out=0, carry_reg=0, idx=0 and busy=0, and in_ready SHALL be 1 after release.
REQ-036 Assertion of rst_n mid-RUN or mid-DONE SHALL abort immediately, and the first request after release SHALL complete correctly.

Verification (W=16, N=4)
REQ-037 Add: a=0x0000_0000_0000_0001, b=0xFFFF_FFFF_FFFF_FFFF, c_in=0, op=0 -> sum=0, c_out=1, out_valid 4 edges after accept.
REQ-038 Subtract: a=5, b=7, op=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0; a=7, b=5 -> sum=2, c_out=1.
REQ-039 Backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 -> sum and c_out stable, in_ready=0, no accept; out_ready=1 -> IDLE, then accept on the following edge.
REQ-040 Carry-in chain: a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> sum=0, c_out=1, with slice_cin=1 observed on all 4 RUN cycles.
REQ-041 clr asserted with idx=2 -> out_valid never rises, IDLE next edge, next request a=3, b=4 -> sum=7.
REQ-042 rst_n pulsed low with idx=1 -> all outputs at reset values during reset, next request a=0x1_0000, b=0xFFFF -> sum=0x1_FFFF, c_out=0.
